// File: rtl/qif_pkg.sv
// Shared types for the QIF neuron path: signed current type, clamp bounds,
// control-state encoding and the saturating narrow-to-8-bit helper.
// Pure declarations; no latency, no flow control.
package qif_pkg;

    // Signed current that feeds the neuron's B input
    typedef logic signed [7:0] qif_current_t;

    localparam int QIF_I_MIN = -128;
    localparam int QIF_I_MAX = 127;

    // Width accepted by qif_sat8; callers sign-extend their sums up to this
    localparam int QIF_SUM_W = 32;

    typedef enum logic {
        QS_IDLE = 1'b0,
        QS_RUN  = 1'b1
    } qif_state_t;

    typedef struct packed {
        logic         sat;
        qif_current_t val;
    } qif_sat_t;

    // Clamp a wide signed sum into the 8-bit current range and flag whether
    // the clamp changed the value.
    function automatic qif_sat_t qif_sat8(input logic signed [QIF_SUM_W-1:0] x);
        qif_sat_t r;
        if (x > QIF_I_MAX) begin
            r.sat = 1'b1;
            r.val = 8'sh7f;
        end else if (x < QIF_I_MIN) begin
            r.sat = 1'b1;
            r.val = 8'sh80;
        end else begin
            r.sat = 1'b0;
            r.val = qif_current_t'(x);
        end
        return r;
    endfunction

endpackage

// File: rtl/qif_leak_timer.sv
// Leak tick generator: free-running modulo-PERIOD counter while enabled.
// Latency: tick is combinational from the count register (high in the PERIOD-th enabled cycle).
// No flow control; clear dominates en.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-high reset
//   clear       - synchronously return the count to 0
//   en          - advance the count this cycle
//   tick        - count is at PERIOD-1 and the timer is enabled
module qif_leak_timer
    import qif_pkg::*;
#(
    parameter int PERIOD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    assign at_end = (cnt == CNT_W'(PERIOD - 1));
    assign tick   = en & at_end;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/qif_synapse.sv
// Synaptic current stage: weighted spike sum into a leaky saturating 8-bit accumulator.
// Latency: one cycle from a sampled spike_in to B (B is the accumulator register).
// Backpressure: cfg_ready is low in RUN; writes offered then are dropped, not queued.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-high reset (clears weights too)
//   start, stop          - pulses; IDLE->RUN / RUN->IDLE, stop wins when both are high
//   spike_in[N_IN]       - presynaptic spikes, sampled every RUN cycle
//   cfg_valid/cfg_addr/cfg_data/cfg_ready - signed weight write port (IDLE only)
//   B, sat               - registered signed current and its clamp flag
//   running              - high in RUN
module qif_synapse
    import qif_pkg::*;
#(
    parameter int N_IN         = 4,
    parameter int DECAY_PERIOD = 16,
    parameter int DECAY_SHIFT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [N_IN-1:0]         spike_in,
    input  logic                    cfg_valid,
    input  logic [$clog2(N_IN)-1:0] cfg_addr,
    input  logic [7:0]              cfg_data,
    output logic                    cfg_ready,
    output logic [7:0]              B,
    output logic                    sat,
    output logic                    running
);

    localparam int ADDR_W = $clog2(N_IN);
    // Wide enough for the current plus every weight at full scale
    localparam int SUM_W  = 8 + ADDR_W + 1;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    qif_state_t state;
    qif_state_t state_nxt;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= QS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            QS_IDLE: if (start && !stop) state_nxt = QS_RUN;
            QS_RUN:  if (stop)           state_nxt = QS_IDLE;
            default:                     state_nxt = QS_IDLE;
        endcase
    end

    // Decoded from the state register only, so no input-to-output path
    always_comb begin
        cfg_ready = (state == QS_IDLE);
        running   = (state == QS_RUN);
    end

    // ------------------------------------------------------------------
    // Weight register file
    // ------------------------------------------------------------------
    qif_current_t weights [N_IN];
    logic         cfg_fire;

    assign cfg_fire = cfg_valid & cfg_ready;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int k = 0; k < N_IN; k++) begin
                weights[k] <= '0;
            end
        end else if (cfg_fire) begin
            weights[cfg_addr] <= cfg_data;
        end
    end

    // ------------------------------------------------------------------
    // Leak timer: held at zero in IDLE, so every RUN entry restarts it
    // ------------------------------------------------------------------
    logic tick;

    qif_leak_timer #(
        .PERIOD (DECAY_PERIOD)
    ) u_leak_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == QS_IDLE),
        .en    (state == QS_RUN),
        .tick  (tick)
    );

    // ------------------------------------------------------------------
    // Datapath: leak first, then add this cycle's spikes, then clamp
    // ------------------------------------------------------------------
    qif_current_t             acc;
    logic                     sat_q;
    qif_current_t             acc_dec;
    logic signed [SUM_W-1:0]  spike_sum;
    logic signed [SUM_W-1:0]  total;
    qif_sat_t                 sat_res;

    // acc is signed, so >>> rounds towards -inf; the result magnitude never
    // exceeds |acc|, so the leak itself cannot overflow 8 bits.
    assign acc_dec = tick ? qif_current_t'(acc - (acc >>> DECAY_SHIFT)) : acc;

    always_comb begin
        spike_sum = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (spike_in[k]) begin
                spike_sum = spike_sum + SUM_W'(weights[k]);
            end
        end
    end

    assign total   = SUM_W'(acc_dec) + spike_sum;
    assign sat_res = qif_sat8(QIF_SUM_W'(total));

    // The stop cycle already zeroes the accumulator so B reads 0 from the
    // first IDLE cycle onwards.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc   <= '0;
            sat_q <= 1'b0;
        end else if (state == QS_RUN && !stop) begin
            acc   <= sat_res.val;
            sat_q <= sat_res.sat;
        end else begin
            acc   <= '0;
            sat_q <= 1'b0;
        end
    end

    assign B   = acc;
    assign sat = sat_q;

endmodule
